// File: rtl/rom_loader_receiver_pkg.sv
// Shared types and defaults for the ROM loader receive path.
// Used by the loader FSM and its bench.
package rom_loader_receiver_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 16;
  localparam int DEFAULT_ADDRESS_WIDTH = 16;
  localparam int DEFAULT_SYNC_STAGES   = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SCK = 2'd1,
    WRITE    = 2'd2,
    ACK      = 2'd3
  } loader_state_e;

endpackage

// File: rtl/rom_loader_receiver_sync.sv
// Multi-flop synchronizer for a single asynchronous level.
// The output is the last stage of the chain.
module signal_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // shift the raw level one stage per clock
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // chain registers, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/rom_loader_receiver.sv
// SoC end of the ROM loading link: 4-phase word receive,
// write to the QSPI ROM controller, then acknowledge.
module rom_loader_receiver
  import rom_loader_receiver_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rom_loader_load,
  input  logic                     rom_loader_sck,
  input  logic [DATA_WIDTH-1:0]    rom_loader_data,
  output logic                     rom_loader_ack,
  output logic                     mem_write_req,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic                     mem_write_done,
  output logic                     loading,
  output logic [ADDRESS_WIDTH-1:0] word_count,
  output logic                     overflow
);

  logic load_s;
  logic sck_s;

  signal_synchronizer #(.STAGES(SYNC_STAGES)) u_load_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (rom_loader_load),
    .q     (load_s)
  );

  signal_synchronizer #(.STAGES(SYNC_STAGES)) u_sck_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (rom_loader_sck),
    .q     (sck_s)
  );

  loader_state_e             state_q, state_d;
  logic                      req_q, req_d;
  logic                      ack_q, ack_d;
  logic                      loading_q, loading_d;
  logic                      ovf_q, ovf_d;
  logic [ADDRESS_WIDTH-1:0]  addr_q, addr_d;
  logic [ADDRESS_WIDTH-1:0]  count_q, count_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [ADDRESS_WIDTH:0]    addr_inc;

  // carry out of the address increment marks a wrap
  assign addr_inc = {1'b0, addr_q} + (ADDRESS_WIDTH+1)'(1);

  // next-state and registered-output logic for the loader FSM
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    ack_d     = ack_q;
    loading_d = loading_q;
    ovf_d     = ovf_q;
    addr_d    = addr_q;
    count_d   = count_q;
    wdata_d   = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (load_s) begin
          addr_d    = '0;
          count_d   = '0;
          ovf_d     = 1'b0;
          loading_d = 1'b1;
          state_d   = WAIT_SCK;
        end
      end
      WAIT_SCK: begin
        if (!load_s) begin
          loading_d = 1'b0;
          state_d   = IDLE;
        end else if (sck_s) begin
          wdata_d = rom_loader_data;
          req_d   = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        // a started write always runs to completion
        if (mem_write_done) begin
          req_d   = 1'b0;
          ack_d   = 1'b1;
          addr_d  = addr_inc[ADDRESS_WIDTH-1:0];
          count_d = count_q + ADDRESS_WIDTH'(1);
          if (addr_inc[ADDRESS_WIDTH]) begin
            ovf_d = 1'b1;
          end
          state_d = ACK;
        end
      end
      ACK: begin
        if (!load_s) begin
          ack_d     = 1'b0;
          loading_d = 1'b0;
          state_d   = IDLE;
        end else if (!sck_s) begin
          ack_d   = 1'b0;
          state_d = WAIT_SCK;
        end
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      ack_q     <= 1'b0;
      loading_q <= 1'b0;
      ovf_q     <= 1'b0;
      addr_q    <= '0;
      count_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      ack_q     <= ack_d;
      loading_q <= loading_d;
      ovf_q     <= ovf_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      wdata_q   <= wdata_d;
    end
  end

  assign rom_loader_ack = ack_q;
  assign mem_write_req  = req_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign loading        = loading_q;
  assign word_count     = count_q;
  assign overflow       = ovf_q;

endmodule
